// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sd_pkg
// Description : Constants, state encoding and the CRC16 bit-step function
//               shared by the SD SPI-mode command shifter, writer FSM and
//               the block data-phase engines.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  // Data-phase transmit states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TOKEN = 2'd1,
    ST_DATA  = 2'd2,
    ST_CRC   = 2'd3
  } sd_tx_state_t;

  // One bit of CRC16-CCITT (poly 0x1021, non-reflected), MSB-first input.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc16_serial
// Description : Bit-serial CRC16 (poly 0x1021, init 0) accumulator. Shared by
//               the transmit and receive data paths.
// Revision    : 1.0 - initial release
// Ports       : clk      - system clock, rising edge
//               resetAll - asynchronous active-low reset
//               i_clr    - synchronous clear to zero (wins over i_en)
//               i_en     - consume i_bit this cycle
//               i_bit    - serial input bit, MSB first
//               o_crc    - current CRC register
// ============================================================================
module sd_crc16_serial
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        resetAll,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk or negedge resetAll) begin
    if (!resetAll) begin
      r_crc <= 16'h0000;
    end else if (i_clr) begin
      r_crc <= 16'h0000;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit);
    end
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_block_tx.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_tx
// Description : SPI-mode SD write data-phase engine. Shifts the start token,
//               BLOCK_BYTES bytes from a show-ahead FIFO and the trailing
//               CRC16 onto MOSI, MSB first, one bit per enabled clock.
// Revision    : 1.0 - initial release
// Ports       : clk            - system clock, rising edge
//               resetAll       - asynchronous active-low reset
//               startCountData - one-cycle start pulse (honoured in IDLE)
//               count          - shift enable; low freezes all state
//               byteEnable     - permits FIFO loads; low at a load stalls
//               dataIn[7:0]    - FIFO head byte
//               dataRd         - FIFO pop strobe (combinational)
//               mosi           - serial data to the card
//               bytes          - pulse: token sent, data phase entered
//               block          - pulse: last data bit sent
//               endCRC         - pulse: last CRC bit sent
//               busy           - engine not idle
// ============================================================================
module sd_block_tx
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES = 512,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       resetAll,
  input  logic       startCountData,
  input  logic       count,
  input  logic       byteEnable,
  input  logic [7:0] dataIn,
  output logic       dataRd,
  output logic       mosi,
  output logic       bytes,
  output logic       block,
  output logic       endCRC,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] ONE_BYTE  = CNT_W'(1);

  sd_tx_state_t     r_state;
  logic [7:0]       r_shreg;
  logic [2:0]       r_bitCnt;
  logic [CNT_W-1:0] r_byteCnt;
  logic [3:0]       r_crcIdx;
  logic             r_bytes;
  logic             r_block;
  logic             r_endCRC;

  logic        w_lastBit;
  logic        w_moreBytes;
  logic        w_loadPending;
  logic        w_stall;
  logic        w_step;
  logic        w_crcEn;
  logic        w_crcBit;
  logic        w_crcClr;
  logic [15:0] w_crc;

  // A FIFO load is due at the last bit of the token and of every data byte
  // except the final one; without byteEnable the whole engine waits there.
  assign w_lastBit     = (r_bitCnt == 3'd7);
  assign w_moreBytes   = (r_byteCnt < LAST_BYTE);
  assign w_loadPending = w_lastBit &
                         ((r_state == ST_TOKEN) |
                          ((r_state == ST_DATA) & w_moreBytes));
  assign w_stall       = w_loadPending & ~byteEnable;
  assign w_step        = count & ~w_stall;
  assign dataRd        = w_step & w_loadPending;

  // In CRC state feeding back crc[15] cancels the feedback term, so the same
  // accumulator doubles as the output shift register (shift left, fill 0).
  assign w_crcEn  = w_step & ((r_state == ST_DATA) | (r_state == ST_CRC));
  assign w_crcBit = (r_state == ST_DATA) ? r_shreg[7] : w_crc[15];
  assign w_crcClr = w_step & (r_state == ST_CRC) & (r_crcIdx == 4'd15);

  sd_crc16_serial u_crc (
    .clk      (clk),
    .resetAll (resetAll),
    .i_clr    (w_crcClr),
    .i_en     (w_crcEn),
    .i_bit    (w_crcBit),
    .o_crc    (w_crc)
  );

  always_ff @(posedge clk or negedge resetAll) begin
    if (!resetAll) begin
      r_state   <= ST_IDLE;
      r_shreg   <= 8'hFF;
      r_bitCnt  <= 3'd0;
      r_byteCnt <= '0;
      r_crcIdx  <= 4'd0;
      r_bytes   <= 1'b0;
      r_block   <= 1'b0;
      r_endCRC  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle regardless of count.
      r_bytes  <= 1'b0;
      r_block  <= 1'b0;
      r_endCRC <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Start takes priority; no bit is shifted on the start edge.
          if (startCountData) begin
            r_state  <= ST_TOKEN;
            r_shreg  <= START_TOKEN;
            r_bitCnt <= 3'd0;
          end
        end
        ST_TOKEN: begin
          if (w_step) begin
            if (w_lastBit) begin
              r_shreg   <= dataIn;
              r_byteCnt <= '0;
              r_bitCnt  <= 3'd0;
              r_state   <= ST_DATA;
              r_bytes   <= 1'b1;
            end else begin
              r_shreg  <= {r_shreg[6:0], 1'b1};
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_step) begin
            if (w_lastBit && w_moreBytes) begin
              r_shreg   <= dataIn;
              r_byteCnt <= r_byteCnt + ONE_BYTE;
              r_bitCnt  <= 3'd0;
            end else if (w_lastBit) begin
              r_shreg  <= {r_shreg[6:0], 1'b1};
              r_bitCnt <= 3'd0;
              r_crcIdx <= 4'd0;
              r_state  <= ST_CRC;
              r_block  <= 1'b1;
            end else begin
              r_shreg  <= {r_shreg[6:0], 1'b1};
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end
        ST_CRC: begin
          if (w_step) begin
            r_crcIdx <= r_crcIdx + 4'd1;
            if (r_crcIdx == 4'd15) begin
              r_state  <= ST_IDLE;
              r_endCRC <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mosi = 1'b1;
    case (r_state)
      ST_TOKEN, ST_DATA: mosi = r_shreg[7];
      ST_CRC:            mosi = w_crc[15];
      default:           mosi = 1'b1;
    endcase
  end

  assign busy   = (r_state != ST_IDLE);
  assign bytes  = r_bytes;
  assign block  = r_block;
  assign endCRC = r_endCRC;

  // The CRC register is always cleared on the way back to IDLE.
  a_crc_zero_in_idle: assert property (
    @(posedge clk) disable iff (!resetAll)
      (r_state == ST_IDLE) |-> (w_crc == 16'h0000));

endmodule
`default_nettype wire

// File: tb/tb_sd_block_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_block_tx
// Description : Self-checking bench for sd_block_tx. Two instances: a 9-byte
//               block and the default 512-byte block. Expected MOSI streams
//               are built from the token, FIFO contents and a reference CRC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_block_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetAll, start9, start512, count, byteEnable;
  logic [7:0] dataIn9, dataIn512;
  logic       dataRd9, mosi9, bytes9, block9, endCRC9, busy9;
  logic       dataRd512, mosi512, bytes512, block512, endCRC512, busy512;

  sd_block_tx #(.BLOCK_BYTES(9), .CNT_W(4)) dut9 (
    .clk(clk), .resetAll(resetAll), .startCountData(start9), .count(count),
    .byteEnable(byteEnable), .dataIn(dataIn9), .dataRd(dataRd9), .mosi(mosi9),
    .bytes(bytes9), .block(block9), .endCRC(endCRC9), .busy(busy9));

  sd_block_tx dut512 (
    .clk(clk), .resetAll(resetAll), .startCountData(start512), .count(count),
    .byteEnable(byteEnable), .dataIn(dataIn512), .dataRd(dataRd512),
    .mosi(mosi512), .bytes(bytes512), .block(block512), .endCRC(endCRC512),
    .busy(busy512));

  int errors = 0;
  int checks = 0;

  // Show-ahead FIFO models
  logic [7:0] mem9   [0:8];
  logic [7:0] mem512 [0:511];
  int rd9, rd512;
  bit sel;

  always @(posedge clk or negedge resetAll) begin
    if (!resetAll) begin
      rd9   <= 0;
      rd512 <= 0;
    end else begin
      if (dataRd9)   rd9   <= rd9 + 1;
      if (dataRd512) rd512 <= rd512 + 1;
    end
  end

  assign dataIn9   = (rd9 < 9)     ? mem9[rd9]     : 8'hA5;
  assign dataIn512 = (rd512 < 512) ? mem512[rd512] : 8'hA5;

  logic w_mosi, w_rd, w_bytes, w_block, w_end, w_busy;
  assign w_mosi  = sel ? mosi512   : mosi9;
  assign w_rd    = sel ? dataRd512 : dataRd9;
  assign w_bytes = sel ? bytes512  : bytes9;
  assign w_block = sel ? block512  : block9;
  assign w_end   = sel ? endCRC512 : endCRC9;
  assign w_busy  = sel ? busy512   : busy9;

  function automatic logic [7:0] get_byte(input bit big, input int i);
    return big ? mem512[i] : mem9[i];
  endfunction

  // XMODEM-style CRC16 of the block payload, bit by bit.
  function automatic logic [15:0] crc_of(input bit big);
    logic [15:0] c;
    logic [7:0]  b;
    int n;
    n = big ? 512 : 9;
    c = 16'h0000;
    for (int i = 0; i < n; i++) begin
      b = get_byte(big, i);
      for (int k = 7; k >= 0; k--) begin
        if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h1021;
        else              c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  task automatic apply_reset();
    resetAll = 1'b0; count = 1'b0; start9 = 1'b0; start512 = 1'b0;
    byteEnable = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetAll = 1'b1;
  endtask

  // Runs one block on the selected instance, comparing every cycle against the
  // expected bit stream. A step happens when count is high unless a FIFO load
  // is due (last bit of token or of a non-final data byte) with byteEnable low.
  task automatic drive_block(input bit big, input bit rnd, input int stall_p,
                             input int stall_len, input int start_p,
                             input int abort_p, output logic [15:0] obs);
    int n, total, p, cyc, stall_cnt, pops;
    logic exp_bits[$];
    logic [15:0] c;
    logic [7:0] b;
    logic exp_step, exp_rd, m, boundary;
    bit start_done;
    n = big ? 512 : 9;
    total = 8 + 8 * n + 16;
    sel = big;
    exp_bits = {};
    b = 8'hFE;
    for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
    for (int i = 0; i < n; i++) begin
      b = get_byte(big, i);
      for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
    end
    c = crc_of(big);
    for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
    obs = 16'h0000; p = 0; cyc = 0; stall_cnt = 0; start_done = 0;

    // Start together with count: the start must win with no shift.
    count = 1'b1; byteEnable = 1'b1;
    if (big) start512 = 1'b1; else start9 = 1'b1;
    #1;
    checks++;
    if (w_busy !== 1'b0 || w_mosi !== 1'b1) begin
      errors++;
      $display("FAIL idle_pre_start busy=%b mosi=%b required busy=0 mosi=1", w_busy, w_mosi);
    end
    @(posedge clk); #1;
    start9 = 1'b0; start512 = 1'b0;
    checks++;
    if (w_busy !== 1'b1 || w_bytes !== 1'b0) begin
      errors++;
      $display("FAIL start_state busy=%b bytes=%b required busy=1 bytes=0", w_busy, w_bytes);
    end

    while (p < total && cyc < 4 * total + 64) begin
      cyc++;
      count = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      boundary = ((p % 8) == 7) && (p < 8 * n);
      if (p == stall_p && stall_cnt < stall_len) begin
        byteEnable = 1'b0; stall_cnt++;
      end else if (rnd) begin
        byteEnable = 1'($urandom_range(0, 1));
      end else begin
        byteEnable = 1'b1;
      end
      if (p == start_p && !start_done) begin
        if (big) start512 = 1'b1; else start9 = 1'b1;
        start_done = 1;
      end
      if (p == abort_p) begin
        resetAll = 1'b0;
        #1;
        checks++;
        if (w_mosi !== 1'b1 || w_busy !== 1'b0 || w_rd !== 1'b0) begin
          errors++;
          $display("FAIL abort_immediate mosi=%b busy=%b rd=%b required 1 0 0", w_mosi, w_busy, w_rd);
        end
        @(posedge clk); #1;
        checks++;
        if (w_bytes !== 1'b0 || w_block !== 1'b0 || w_end !== 1'b0 || w_busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_pulses bytes=%b block=%b end=%b busy=%b required all 0",
                   w_bytes, w_block, w_end, w_busy);
        end
        resetAll = 1'b1;
        return;
      end
      #1;
      exp_step = count && !(boundary && !byteEnable);
      exp_rd   = exp_step && boundary;
      m = w_mosi;
      checks++;
      if (m !== exp_bits[p]) begin
        errors++;
        $display("FAIL mosi step=%0d got %b required %b", p, m, exp_bits[p]);
      end
      checks++;
      if (w_rd !== exp_rd) begin
        errors++;
        $display("FAIL dataRd step=%0d got %b required %b", p, w_rd, exp_rd);
      end
      checks++;
      if (w_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy step=%0d got %b required 1", p, w_busy);
      end
      @(posedge clk); #1;
      start9 = 1'b0; start512 = 1'b0;
      checks++;
      if (w_bytes !== (exp_step && p == 7) || w_block !== (exp_step && p == 8 * n + 7) ||
          w_end !== (exp_step && p == total - 1)) begin
        errors++;
        $display("FAIL pulses step=%0d bytes=%b block=%b end=%b required %b %b %b", p,
                 w_bytes, w_block, w_end, (exp_step && p == 7),
                 (exp_step && p == 8 * n + 7), (exp_step && p == total - 1));
      end
      if (exp_step) begin
        if (p >= 8 + 8 * n) obs = {obs[14:0], m};
        p++;
      end
    end

    count = 1'b0; byteEnable = 1'b1;
    checks++;
    if (p != total) begin
      errors++;
      $display("FAIL timeout steps=%0d required %0d", p, total);
    end
    #1;
    pops = big ? rd512 : rd9;
    checks++;
    if (w_busy !== 1'b0 || w_mosi !== 1'b1 || w_rd !== 1'b0) begin
      errors++;
      $display("FAIL end_idle busy=%b mosi=%b rd=%b required 0 1 0", w_busy, w_mosi, w_rd);
    end
    checks++;
    if (pops != n) begin
      errors++;
      $display("FAIL pop_count got %0d required %0d", pops, n);
    end
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) mem9[i] = 8'(8'h31 + i);
  endtask

  task automatic test_reset();
    resetAll = 1'b0; count = 1'b1; start9 = 1'b1; start512 = 1'b1; byteEnable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mosi9 !== 1'b1 || busy9 !== 1'b0 || dataRd9 !== 1'b0 ||
        bytes9 !== 1'b0 || block9 !== 1'b0 || endCRC9 !== 1'b0) begin
      errors++;
      $display("FAIL reset9 mosi=%b busy=%b rd=%b pulses=%b%b%b required 1 0 0 000",
               mosi9, busy9, dataRd9, bytes9, block9, endCRC9);
    end
    checks++;
    if (mosi512 !== 1'b1 || busy512 !== 1'b0 || dataRd512 !== 1'b0) begin
      errors++;
      $display("FAIL reset512 mosi=%b busy=%b rd=%b required 1 0 0", mosi512, busy512, dataRd512);
    end
    start9 = 1'b0; start512 = 1'b0; count = 1'b0;
    #1 resetAll = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] obs;
    apply_reset();
    load_digits();
    drive_block(1'b0, 1'b0, -1, 0, -1, -1, obs);
    checks++;
    if (obs !== 16'h31C3) begin
      errors++;
      $display("FAIL basic_crc got %h required 31c3", obs);
    end
  endtask

  task automatic test_count_gaps();
    logic [15:0] obs;
    apply_reset();
    load_digits();
    drive_block(1'b0, 1'b1, -1, 0, -1, -1, obs);
    checks++;
    if (obs !== 16'h31C3) begin
      errors++;
      $display("FAIL gaps_crc got %h required 31c3", obs);
    end
  endtask

  task automatic test_stall();
    logic [15:0] obs;
    apply_reset();
    load_digits();
    // Load boundary for data byte 3: last bit of byte 2.
    drive_block(1'b0, 1'b0, 8 + 8 * 2 + 7, 5, -1, -1, obs);
    checks++;
    if (obs !== 16'h31C3) begin
      errors++;
      $display("FAIL stall_crc got %h required 31c3", obs);
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] obs;
    apply_reset();
    for (int i = 0; i < 9; i++) mem9[i] = 8'($urandom);
    drive_block(1'b0, 1'b0, -1, 0, 8 + 8 * 4 + 2, -1, obs);
    checks++;
    if (obs !== crc_of(1'b0)) begin
      errors++;
      $display("FAIL restart_ignored_crc got %h required %h", obs, crc_of(1'b0));
    end
  endtask

  task automatic test_zero_512();
    logic [15:0] obs;
    apply_reset();
    for (int i = 0; i < 512; i++) mem512[i] = 8'h00;
    drive_block(1'b1, 1'b0, -1, 0, -1, -1, obs);
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL zero_crc got %h required 0000", obs);
    end
  endtask

  task automatic test_abort();
    logic [15:0] obs;
    apply_reset();
    for (int i = 0; i < 512; i++) mem512[i] = 8'($urandom);
    drive_block(1'b1, 1'b0, -1, 0, -1, 8 + 8 * 100 + 3, obs);
    // Reset also flushed the FIFO model; a new start must send a clean block.
    @(posedge clk); #1;
    drive_block(1'b1, 1'b0, -1, 0, -1, -1, obs);
    checks++;
    if (obs !== crc_of(1'b1)) begin
      errors++;
      $display("FAIL abort_restart_crc got %h required %h", obs, crc_of(1'b1));
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_basic();
    test_count_gaps();
    test_stall();
    test_start_ignored();
    test_zero_512();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
